// File: rtl/piece_bag_queue_if.sv
// Handshake between the game FSM / renderers and the piece queue.
// The master side consumes pieces and reseeds; the slave side is the queue itself.
interface piece_bag_queue_if #(
    parameter int PREVIEW_DEPTH = 3,
    parameter int LFSR_WIDTH    = 16
);
    logic                       enable;
    logic                       seed_load;
    logic [LFSR_WIDTH-1:0]      seed_in;
    logic                       ready;
    logic [2:0]                 cur_idx;
    logic [3*PREVIEW_DEPTH-1:0] preview_idx;
    logic [15:0]                pieces_dealt;

    modport master (
        output enable, seed_load, seed_in,
        input  ready, cur_idx, preview_idx, pieces_dealt
    );

    modport slave (
        input  enable, seed_load, seed_in,
        output ready, cur_idx, preview_idx, pieces_dealt
    );
endinterface

// File: rtl/piece_bag_queue.sv
// Current tetromino plus a PREVIEW_DEPTH-slot preview queue, refilled one piece per cycle from a
// free-running 16-bit Galois LFSR using either a 7-bag shuffle or a no-immediate-repeat draw.
module piece_bag_queue #(
    parameter int                    PREVIEW_DEPTH = 3,
    parameter int                    LFSR_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1,
    parameter int                    BAG_MODE      = 1
) (
    input logic              clk,
    input logic              rst,
    piece_bag_queue_if.slave bus
);

    localparam int                    QDEPTH    = PREVIEW_DEPTH + 1;
    localparam int                    CNT_W     = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0]      LAST_SLOT = CNT_W'(PREVIEW_DEPTH);
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(16'hB400);
    localparam logic [6:0]            BAG_FULL  = 7'h7F;
    localparam logic [2:0]            NO_PIECE  = 3'd7;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Inputs never exceed 13, so a single conditional subtract is a full mod 7.
    function automatic logic [2:0] mod7(input logic [3:0] v);
        return (v >= 4'd7) ? 3'(v - 4'd7) : v[2:0];
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ready;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [LFSR_WIDTH-1:0] w_lfsr_next;
    logic [LFSR_WIDTH-1:0] w_seed_val;

    logic [2:0]            r_queue [QDEPTH];
    logic [CNT_W-1:0]      r_fill_cnt;
    logic [6:0]            r_bag_mask;
    logic [2:0]            r_last;
    logic [15:0]           r_pieces_dealt;

    logic                  w_accept;
    logic                  w_fill_draw;
    logic                  w_draw_en;

    logic [2:0]            w_r;
    logic [7:0]            w_avail;
    logic [2:0]            w_scan_start;
    logic                  w_found;
    logic [2:0]            w_bag_pick;
    logic [6:0]            w_bag_next;
    logic [2:0]            w_rand_base;
    logic [2:0]            w_rand_pick;
    logic [2:0]            w_draw;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_seed_val  = (bus.seed_in == '0) ? SEED : bus.seed_in;

    // seed_load outranks enable, and no draw happens in its cycle.
    assign w_accept    = (r_state == ST_READY) && bus.enable && !bus.seed_load;
    assign w_fill_draw = (r_state == ST_FILL) && !bus.seed_load;
    assign w_draw_en   = w_accept || w_fill_draw;

    assign w_r     = r_lfsr[2:0];
    assign w_avail = {1'b0, r_bag_mask};

    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        w_scan_start = (w_r == NO_PIECE) ? 3'd0 : mod7({1'b0, w_r} + 4'd1);
        w_bag_pick   = w_r;
        w_found      = w_avail[w_r];
        for (int i = 0; i < 7; i++) begin
            if (!w_found && w_avail[mod7({1'b0, w_scan_start} + 4'(i))]) begin
                w_bag_pick = mod7({1'b0, w_scan_start} + 4'(i));
                w_found    = 1'b1;
            end
        end
        w_bag_next = r_bag_mask & ~(7'd1 << w_bag_pick);
        if (w_bag_next == '0) begin
            w_bag_next = BAG_FULL;
        end
    end

    assign w_rand_base = (w_r == NO_PIECE) ? mod7({1'b0, r_lfsr[5:3]}) : w_r;
    assign w_rand_pick = (w_rand_base == r_last)
                       ? mod7({1'b0, w_rand_base} + 4'd1 + {3'b000, r_lfsr[6]})
                       : w_rand_base;
    assign w_draw      = (BAG_MODE != 0) ? w_bag_pick : w_rand_pick;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.seed_load) begin
            w_state_next = ST_FILL;
        end else begin
            case (r_state)
                ST_FILL:  if (r_fill_cnt == LAST_SLOT) w_state_next = ST_READY;
                ST_READY: w_state_next = ST_READY;
                default:  w_state_next = ST_FILL;
            endcase
        end
    end

    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_READY: w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    // NOTE: the queue is a handful of flops whose zero value is visible on the outputs, so it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr         <= SEED;
            r_fill_cnt     <= '0;
            r_bag_mask     <= BAG_FULL;
            r_last         <= NO_PIECE;
            r_pieces_dealt <= '0;
            for (int k = 0; k < QDEPTH; k++) begin
                r_queue[k] <= '0;
            end
        end else if (bus.seed_load) begin
            r_lfsr     <= w_seed_val;
            r_fill_cnt <= '0;
            r_bag_mask <= BAG_FULL;
            r_last     <= NO_PIECE;
            for (int k = 0; k < QDEPTH; k++) begin
                r_queue[k] <= '0;
            end
        end else begin
            r_lfsr <= w_lfsr_next;
            if (w_fill_draw) begin
                for (int k = 0; k < QDEPTH; k++) begin
                    if (r_fill_cnt == CNT_W'(k)) r_queue[k] <= w_draw;
                end
                r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                for (int k = 0; k < PREVIEW_DEPTH; k++) begin
                    r_queue[k] <= r_queue[k+1];
                end
                r_queue[PREVIEW_DEPTH] <= w_draw;
                r_pieces_dealt         <= r_pieces_dealt + 16'd1;
            end
            if (w_draw_en) begin
                r_bag_mask <= w_bag_next;
                r_last     <= w_draw;
            end
        end
    end

    assign bus.ready        = w_ready;
    assign bus.cur_idx      = r_queue[0];
    assign bus.pieces_dealt = r_pieces_dealt;

    for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
        assign bus.preview_idx[3*k +: 3] = r_queue[k+1];
    end

endmodule

// File: doc/piece_bag_queue.md
# piece_bag_queue

Parametrised successor to the single-lookahead tetromino generator. Holds the current piece plus a configurable-depth preview queue, and refills the queue one piece per cycle from a free-running LFSR. Pieces are drawn either with a 7-bag shuffle or as random draws with no immediate repeats. Sits between the game FSM, which pulses `enable` to consume a piece, and the tetromino shape lookup and preview renderer, which read the indices.

## Interface

- PREVIEW_DEPTH, 3, number of preview slots after the current piece; legal range 1..6
- LFSR_WIDTH, 16, LFSR width; fixed at 16 because the taps are defined for 16
- SEED, 16'hACE1, LFSR value after reset, and the substitute whenever `seed_in` is 0
- BAG_MODE, 1, 1 = 7-bag shuffle, 0 = random draw with no immediate repeat
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  consume the current piece; acted on only when `ready`=1, once per cycle while held
- seed_load  input  1  load `seed_in`, then flush and refill
- seed_in  input  LFSR_WIDTH  seed value; 0 is replaced by SEED
- ready  output  1  the queue holds PREVIEW_DEPTH+1 valid pieces
- cur_idx  output  3  current piece index, 0..6 (`TETROMINO_I_IDX`=0 .. `TETROMINO_Z_IDX`=6)
- preview_idx  output  3*PREVIEW_DEPTH  preview slots; slot k is at bits [3k+2:3k], and slot 0 is next
- pieces_dealt  output  16  count of accepted enables; wraps modulo 2^16

## Operation

- **LFSR**: 16-bit Galois, mask 16'hB400, shifted right every cycle unconditionally.
- **Queue**: PREVIEW_DEPTH+1 entries. Entry 0 drives `cur_idx`; entry k drives preview slot k-1. The write pointer `fill_cnt` runs 0..PREVIEW_DEPTH+1.
- **Draw, common**: r = lfsr[2:0].
- **Draw, BAG_MODE=1**:
  - `bag_mask[6:0]` marks the pieces still available (1 = available).
  - If r==7 or bag_mask[r]==0, pick the first available index scanning r+1, r+2, … mod 7, where r==7 starts the scan at 0.
  - Clear the chosen bit. If the mask becomes all-zero, reload it to 7'h7F in the same cycle.
- **Draw, BAG_MODE=0**:
  - If r==7, r = lfsr[5:3] mod 7.
  - If r equals the last drawn piece, r = (r+1+lfsr[6]) mod 7.
  - `last` updates on every draw.
- **FSM states**: FILL, READY.
  - **FILL**: draw one piece per cycle into entry `fill_cnt` and increment `fill_cnt`. When `fill_cnt` reaches PREVIEW_DEPTH+1, go to READY. `ready`=0, and `enable` is ignored.
  - **READY**: `ready`=1. An accepted `enable` shifts the queue (entry k ← entry k+1), writes a fresh draw into the last entry and increments `pieces_dealt`, all in one cycle. Without `enable`, no draw happens and bag/last are unchanged.
- **seed_load**, in any state:
  - lfsr ← (seed_in==0 ? SEED : seed_in).
  - Queue entries ← 0, `fill_cnt` ← 0, bag_mask ← 7'h7F, last ← 7 (none), state ← FILL.
  - `pieces_dealt` is not cleared.
- **Priority**: rst > seed_load > enable. An `enable` in the same cycle as `seed_load` is dropped.
- **Arithmetic**: all mod-7 operations are on 3-bit values with at most 4-bit intermediates. Index 7 is never written to the queue.

## Timing

- **Reset values** (asynchronous, immediate on `rst` assertion):
  - `ready`=0, `cur_idx`=0, `preview_idx`=0, `pieces_dealt`=0.
  - lfsr=SEED, bag_mask=7'h7F, last=7, state FILL, `fill_cnt`=0.
- **Fill latency**: the first rising edge after `rst` deasserts writes entry 0. `ready` rises after edge PREVIEW_DEPTH+1, i.e. after 4 edges for the default depth.
- **Consume latency**: one cycle. After the accepting edge, `cur_idx` equals the pre-edge preview slot 0.
- **Sustained enable**: holding `enable` high in READY consumes one piece per cycle with no bubbles, and `ready` stays 1.
- **seed_load**: `ready` falls on the following edge. Refill takes PREVIEW_DEPTH+1 further edges.
- **Mid-operation reset**: all state is cleared at once, with no partial shift.
- **Bag property**: after each FILL start, pieces drawn 1..7, 8..14, … are each a permutation of 0..6.

## Test plan

1. **Reset and fill**: assert rst for 2 cycles, release, enable=0.
   - `ready` must be 0 for 3 edges and 1 after the 4th (PREVIEW_DEPTH=3).
   - All four indices must be in 0..6, and `pieces_dealt`=0.
2. **Bag permutation**: BAG_MODE=1, hold `enable` for 70 cycles after `ready`.
   - Reconstruct the draw order from the fill plus the tail entries.
   - Each of the 10 consecutive 7-groups must be a permutation of 0..6.
   - Each new `cur_idx` must equal the previous preview slot 0.
   - `pieces_dealt` must equal 70.
3. **Random mode**: BAG_MODE=0, 1000 enables.
   - No two consecutive drawn pieces may be equal, and no index may be 7.
   - All 7 indices must appear.
4. **Seed reproducibility**: drive `seed_load` with seed_in=16'h1234, then an identical enable pattern, twice.
   - The two `cur_idx` sequences must be identical.
   - seed_in=0 must give the same sequence as seed_in=16'hACE1.
5. **Ignored enable and mid-run reset**:
   - `enable` high during FILL must leave `pieces_dealt` unchanged.
   - `enable` together with `seed_load` must not count.
   - Asserting rst mid-stream must drop `ready`, `cur_idx` and `pieces_dealt` to 0 before the next clock edge.
6. **Counter wrap**: force `pieces_dealt` to 16'hFFFF, or run 65536 enables, then accept one more enable; `pieces_dealt` must read 0.
